// File: rtl/light_pkg.sv
// Shared state and lamp codes for the traffic-light sequencer.
package light_pkg;

  localparam int unsigned StateW = 3;
  localparam int unsigned LampW  = 2;

  typedef enum logic [StateW-1:0] {
    StAg = 3'd0,
    StAy = 3'd1,
    StAr = 3'd2,
    StBg = 3'd3,
    StBy = 3'd4,
    StBr = 3'd5,
    StPw = 3'd6
  } state_t;

  typedef enum logic [LampW-1:0] {
    LampG = 2'b00,
    LampY = 2'b01,
    LampR = 2'b10
  } lamp_t;

endpackage

// File: rtl/light_seq_ctrl_if.sv
// Sensor/lamp bundle of the sequencer; slave is the controller, master drives the sensors.
interface light_seq_ctrl_if;
  import light_pkg::*;

  logic              TA;
  logic              TB;
  logic              PED_REQ;
  logic              PED_ACK;
  logic              WALK;
  logic [LampW-1:0]  LA;
  logic [LampW-1:0]  LB;
  logic [StateW-1:0] STATE;

  modport master (
    output TA, TB, PED_REQ,
    input  PED_ACK, WALK, LA, LB, STATE
  );

  modport slave (
    input  TA, TB, PED_REQ,
    output PED_ACK, WALK, LA, LB, STATE
  );

endinterface

// File: rtl/light_timer.sv
// Phase timer: synchronous clear, saturating increment, asynchronous reset.
module light_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          clr,
  output logic [TW-1:0] cnt
);
  import light_pkg::*;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/light_seq_ctrl.sv
// Two-street traffic-light sequencer with optional pedestrian walk phase.
// Pedestrian phase and handshake are built only when LIGHT_PED_EN is defined.
module light_seq_ctrl
  import light_pkg::*;
#(
  parameter int unsigned TW        = 8,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned PED_T     = 6
) (
  input  logic             CLK,
  input  logic             RESETB,
  light_seq_ctrl_if.slave  lsc
);

  localparam logic [TW-1:0] GreenLast  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] YellowLast = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AllredLast = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] PedLast    = TW'(PED_T - 1);

  state_t        state_q, state_d;
  logic          next_b_q, next_b_d;
  logic [TW-1:0] timer_q;
  logic          ped_pending;

  light_timer #(
    .TW (TW)
  ) u_timer (
    .CLK    (CLK),
    .RESETB (RESETB),
    .clr    (state_d != state_q),
    .cnt    (timer_q)
  );

  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    unique case (state_q)
      StAg: if (timer_q >= GreenLast && (!lsc.TA || ped_pending)) state_d = StAy;
      StAy: if (timer_q == YellowLast) state_d = StAr;
      StAr: begin
        if (timer_q == AllredLast) begin
          if (ped_pending) begin
            state_d  = StPw;
            next_b_d = 1'b1;
          end else begin
            state_d  = StBg;
          end
        end
      end
      StBg: if (timer_q >= GreenLast && (!lsc.TB || ped_pending)) state_d = StBy;
      StBy: if (timer_q == YellowLast) state_d = StBr;
      StBr: begin
        if (timer_q == AllredLast) begin
          if (ped_pending) begin
            state_d  = StPw;
            next_b_d = 1'b0;
          end else begin
            state_d  = StAg;
          end
        end
      end
      StPw: if (timer_q == PedLast) state_d = next_b_q ? StBg : StAg;
      default: state_d = StAg;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= StAg;
      next_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      next_b_q <= next_b_d;
    end
  end

`ifdef LIGHT_PED_EN
  logic ped_pending_q, ped_pending_d;

  // Clearing on the transition into PW wins; a request made during PW re-arms.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (lsc.PED_REQ) ped_pending_d = 1'b1;
    if (state_q != StPw && state_d == StPw) ped_pending_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ped_pending_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
    end
  end

  assign ped_pending = ped_pending_q;
  assign lsc.WALK    = (state_q == StPw);
  assign lsc.PED_ACK = (state_q == StPw) && (timer_q == '0);
`else
  logic unused_ped_req;

  assign unused_ped_req = lsc.PED_REQ;
  assign ped_pending    = 1'b0;
  assign lsc.WALK       = 1'b0;
  assign lsc.PED_ACK    = 1'b0;
`endif

  always_comb begin
    lsc.LA = LampR;
    lsc.LB = LampR;
    unique case (state_q)
      StAg:    lsc.LA = LampG;
      StAy:    lsc.LA = LampY;
      StBg:    lsc.LB = LampG;
      StBy:    lsc.LB = LampY;
      default: begin
        lsc.LA = LampR;
        lsc.LB = LampR;
      end
    endcase
  end

  assign lsc.STATE = state_q;

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Randomized and directed bench for light_seq_ctrl against a phase/dwell reference model.
module tb_light_seq_ctrl;

  localparam int unsigned TW        = 8;
  localparam int unsigned GREEN_MIN = 8;
  localparam int unsigned YELLOW_T  = 3;
  localparam int unsigned ALLRED_T  = 1;
  localparam int unsigned PED_T     = 6;

`ifdef LIGHT_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int PH_AG = 0, PH_AY = 1, PH_AR = 2, PH_BG = 3, PH_BY = 4, PH_BR = 5, PH_PW = 6;

  logic CLK = 1'b0;
  logic RESETB;
  light_seq_ctrl_if bus ();

  light_seq_ctrl #(
    .TW        (TW),
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .PED_T     (PED_T)
  ) dut (
    .CLK    (CLK),
    .RESETB (RESETB),
    .lsc    (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current phase and number of cycles spent in it (1 = first cycle).
  int ph;
  int dwell;
  bit pend;
  bit walk_to_b;

  function void model_reset();
    ph        = PH_AG;
    dwell     = 1;
    pend      = 1'b0;
    walk_to_b = 1'b0;
  endfunction

  function void model_edge(input bit ta, input bit tb, input bit pr);
    int nph;
    nph = ph;
    case (ph)
      PH_AG: if (dwell >= int'(GREEN_MIN) && (!ta || pend)) nph = PH_AY;
      PH_AY: if (dwell == int'(YELLOW_T)) nph = PH_AR;
      PH_AR: if (dwell == int'(ALLRED_T)) begin
        nph = pend ? PH_PW : PH_BG;
        if (pend) walk_to_b = 1'b1;
      end
      PH_BG: if (dwell >= int'(GREEN_MIN) && (!tb || pend)) nph = PH_BY;
      PH_BY: if (dwell == int'(YELLOW_T)) nph = PH_BR;
      PH_BR: if (dwell == int'(ALLRED_T)) begin
        nph = pend ? PH_PW : PH_AG;
        if (pend) walk_to_b = 1'b0;
      end
      PH_PW: if (dwell == int'(PED_T)) nph = walk_to_b ? PH_BG : PH_AG;
      default: nph = PH_AG;
    endcase
    if (PED_EN) begin
      if (nph == PH_PW && ph != PH_PW) pend = 1'b0;
      else if (pr) pend = 1'b1;
    end
    dwell = (nph != ph) ? 1 : dwell + 1;
    ph    = nph;
  endfunction

  function automatic logic [1:0] lamp_a(input int p);
    case (p)
      PH_AG:   return 2'b00;
      PH_AY:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input int p);
    case (p)
      PH_BG:   return 2'b00;
      PH_BY:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check_outputs();
    logic [8:0] exp_v;
    logic [8:0] obs_v;
    logic [2:0] code;
    logic       bad;
    code  = 3'(ph);
    exp_v = {code, lamp_a(ph), lamp_b(ph), PED_EN && ph == PH_PW,
             PED_EN && ph == PH_PW && dwell == 1};
    obs_v = {bus.STATE, bus.LA, bus.LB, bus.WALK, bus.PED_ACK};
    check_eq("outs{state,la,lb,walk,ack}", 32'(obs_v), 32'(exp_v));
    bad = (bus.LA != 2'b10 && bus.LB != 2'b10) ||
          (bus.WALK && (bus.LA != 2'b10 || bus.LB != 2'b10));
    check_eq("lamp_conflict", 32'(bad), 32'd0);
  endtask

  // Starts and ends on a negedge; the model advances with the DUT on the posedge.
  task automatic step(input bit ta, input bit tb, input bit pr);
    bus.TA      = ta;
    bus.TB      = tb;
    bus.PED_REQ = pr;
    @(posedge CLK);
    if (RESETB) model_edge(ta, tb, pr);
    #1 check_outputs();
    @(negedge CLK);
  endtask

  // Asserts reset between clock edges, checks the asynchronous effect, releases on a negedge.
  task automatic do_reset();
    #2 RESETB = 1'b0;
    model_reset();
    #1;
    check_eq("rst_la", 32'(bus.LA), 32'h0);
    check_eq("rst_lb", 32'(bus.LB), 32'h2);
    check_eq("rst_state", 32'(bus.STATE), 32'h0);
    check_eq("rst_walk_ack", 32'({bus.WALK, bus.PED_ACK}), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESETB = 1'b1;
  endtask

  initial begin
    RESETB      = 1'b0;
    bus.TA      = 1'b0;
    bus.TB      = 1'b0;
    bus.PED_REQ = 1'b0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // A idle, B busy: A cycles out once, then B green is held.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

    // A busy holds green well past the minimum, then yields once traffic drops.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

`ifdef LIGHT_PED_EN
    // One-cycle request in AG, then a second request while walking.
    begin
      bit reached;
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
        step(1'b1, 1'b1, 1'b0);
        reached = (bus.STATE == 3'd6);
      end
      check_eq("reach_pw", 32'(bus.STATE), 32'd6);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0);
    end
`else
    // Request held high: walk phase must stay unreachable.
    do_reset();
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
`endif

    // Reset in the middle of B yellow, then a full-length A green afterwards.
    begin
      bit reached;
      do_reset();
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
        step(1'b0, 1'b0, 1'b0);
        reached = (bus.STATE == 3'd4);
      end
      check_eq("reach_by", 32'(bus.STATE), 32'd4);
      step(1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    end

    // Randomized traffic with sparse pedestrian requests and occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_seq_ctrl.md
LIGHT_SEQ_CTRL -- requirements
Module: light_seq_ctrl

Interface
REQ-001 SHALL have parameter TW, default 8, timer width in bits.
REQ-002 SHALL have parameter GREEN_MIN, default 8, minimum green duration in cycles.
REQ-003 SHALL have parameter YELLOW_T, default 3, yellow duration in cycles.
REQ-004 SHALL have parameter ALLRED_T, default 1, all-red clearance duration in cycles.
REQ-005 SHALL have parameter PED_T, default 6, pedestrian walk duration in cycles; all durations are >=1 and <2**TW.
REQ-006 SHALL have port CLK  input  1  single clock; all state updates occur on posedge CLK.
REQ-007 SHALL have port RESETB  input  1  asynchronous active-low reset.
REQ-008 SHALL have port TA  input  1  traffic present on street A.
REQ-009 SHALL have port TB  input  1  traffic present on street B.
REQ-010 SHALL have port PED_REQ  input  1  pedestrian request, level, sampled each cycle.
REQ-011 SHALL have port PED_ACK  output  1  one-cycle acknowledge of a served request.
REQ-012 SHALL have port WALK  output  1  pedestrian walk lamp.
REQ-013 SHALL have port LA  output  2  street A lamp: G=00, Y=01, R=10.
REQ-014 SHALL have port LB  output  2  street B lamp, same encoding.
REQ-015 SHALL have port STATE  output  3  current state code, for debug.

Function
REQ-016 SHALL implement states AG, AY, AR, BG, BY, BR, PW (codes 0-6); AG: LA=G/LB=R; AY: Y/R; AR, BR, PW: R/R; BG: R/G; BY: R/Y.
REQ-017 SHALL clear the timer to 0 in the cycle after any state change, otherwise increment it, saturating at all-ones.
REQ-018 SHALL leave AG for AY when timer>=GREEN_MIN-1 and (TA=0 or ped_pending=1); BG for BY likewise with TB.
REQ-019 SHALL leave AY for AR, and BY for BR, when timer==YELLOW_T-1.
REQ-020 SHALL, when timer==ALLRED_T-1, go AR->PW if ped_pending else AR->BG, and BR->PW if ped_pending else BR->AG.
REQ-021 SHALL leave PW when timer==PED_T-1, going to BG if PW was entered from AR, else to AG (one-bit next_b flag).
REQ-022 SHALL set ped_pending in any cycle PED_REQ=1, and clear it on the entry cycle into PW; a set and a clear in the same cycle leave ped_pending=1 only if the request arrives during PW itself.
REQ-023 SHALL assert PED_ACK only in the first cycle of PW (state==PW, timer==0), and WALK throughout PW.
REQ-024 SHALL derive LA, LB, WALK, STATE combinationally from state only; no output depends combinationally on TA, TB or PED_REQ.
REQ-025 SHALL never drive G or Y on both streets simultaneously, and never WALK with any G/Y lamp.

Reset
REQ-026 SHALL, while RESETB=0 and independent of CLK, force state=AG, timer=0, ped_pending=0, next_b=0; hence LA=00, LB=10, WALK=0, PED_ACK=0, STATE=0.
REQ-027 SHALL, on reset mid-phase (e.g. in BY or PW), abandon the phase immediately; the first post-reset AG enforces the full GREEN_MIN.

Configuration
REQ-028 SHALL, with LIGHT_PED_EN defined, implement PW and the pedestrian handshake as above.
REQ-029 SHALL, without LIGHT_PED_EN, keep all ports, ignore PED_REQ, tie PED_ACK=0 and WALK=0, make PW unreachable, and treat ped_pending as constant 0.

Structure
REQ-030 SHALL place state codes and lamp codes (G, Y, R) in shared package light_pkg.
REQ-031 SHALL instantiate sub-module light_timer (TW-bit counter, synchronous clear, saturate, async reset) for the phase timer.

Verification
REQ-032 SHALL cover: release reset, TA=0, TB=1, PED_REQ=0 -> LA=G 8 cycles, Y 3, R/R 1, then LB=G held while TB=1.
REQ-033 SHALL cover: TA=1 held -> AG held indefinitely past GREEN_MIN; drop TA at cycle 20 -> AY in the next state cycle.
REQ-034 SHALL cover (LIGHT_PED_EN): one-cycle PED_REQ in AG with TA=1 -> AY, AR, PW with PED_ACK=1 for 1 cycle, WALK 6 cycles, then BG.
REQ-035 SHALL cover: PED_REQ during PW -> second PW after the next BG/BY/BR sequence, then AG.
REQ-036 SHALL cover: RESETB pulsed low mid-BY -> outputs go to LA=00, LB=10 asynchronously; AG lasts 8 cycles afterwards.
REQ-037 SHALL cover (no LIGHT_PED_EN): PED_REQ=1 constant -> PED_ACK and WALK stay 0, PW never entered.
